pc_fetch_unit: RTL and testbench

Program-counter register and instruction-fetch sequencer for the single-issue MIPS core. It holds the current PC and issues word fetches on the instruction bus. It presents fetched instructions with their PC to the IF/ID stage. It consumes the next-PC redirect produced by the jump/branch target 2:1 select stage. A one-entry holding buffer absorbs a bus response that arrives while ID is stalled, and redirects flush in-flight work.

---
 rtl/pc_fetch_unit.sv | 137 +++++++++++++
 tb/tb_pc_fetch_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Purpose  : PC register and instruction-fetch sequencer feeding the IF/ID
//            stage, with a one-entry holding buffer and redirect flush.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             ifid_valid,
    output logic [WIDTH-1:0] ifid_pc,
    output logic [WIDTH-1:0] ifid_instr
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_fetch = 2'd1;
    localparam logic [1:0] c_st_hold  = 2'd2;
    localparam logic [1:0] c_st_drop  = 2'd3;

    localparam logic [WIDTH-1:0] c_pc_step = WIDTH'(4);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_addr;
    logic             r_out;
    logic [WIDTH-1:0] r_hold_instr;
    logic [WIDTH-1:0] r_hold_pc;
    logic             r_ifid_valid;
    logic [WIDTH-1:0] r_ifid_pc;
    logic [WIDTH-1:0] r_ifid_instr;

    logic             w_slot_free;
    logic             w_ack;
    logic             w_pending;
    logic [WIDTH-1:0] w_redirect_pc;
    logic             w_unused_lsbs;

    assign w_slot_free   = !r_ifid_valid || !stall;
    assign w_ack         = imem_req && imem_ack;
    assign w_pending     = imem_req && !imem_ack;
    assign w_redirect_pc = {redirect_pc[WIDTH-1:2], 2'b00};
    assign w_unused_lsbs = ^redirect_pc[1:0];

    // An issued request stays up until ack even if the slot fills meanwhile.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = r_pc;
        case (r_state)
            c_st_fetch: imem_req = r_out || w_slot_free;
            c_st_drop: begin
                imem_req  = 1'b1;
                imem_addr = r_addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_pc         <= RESET_PC;
            r_addr       <= RESET_PC;
            r_out        <= 1'b0;
            r_hold_instr <= '0;
            r_hold_pc    <= '0;
            r_ifid_valid <= 1'b0;
            r_ifid_pc    <= '0;
            r_ifid_instr <= '0;
        end else begin
            r_out <= w_pending;
            // Freeze the address of the abandoned request while draining it.
            if (r_state != c_st_drop) begin
                r_addr <= r_pc;
            end
            if (r_ifid_valid && !stall) begin
                r_ifid_valid <= 1'b0;
            end

            if (redirect_valid) begin
                r_pc         <= w_redirect_pc;
                r_ifid_valid <= 1'b0;
                r_hold_instr <= '0;
                r_hold_pc    <= '0;
                r_state      <= w_pending ? c_st_drop : c_st_fetch;
            end else begin
                case (r_state)
                    c_st_idle: r_state <= c_st_fetch;
                    c_st_fetch: begin
                        if (w_ack) begin
                            r_pc <= r_pc + c_pc_step;
                            if (w_slot_free) begin
                                r_ifid_valid <= 1'b1;
                                r_ifid_pc    <= r_pc;
                                r_ifid_instr <= imem_rdata;
                            end else begin
                                r_hold_instr <= imem_rdata;
                                r_hold_pc    <= r_pc;
                                r_state      <= c_st_hold;
                            end
                        end
                    end
                    c_st_hold: begin
                        if (!stall) begin
                            r_ifid_valid <= 1'b1;
                            r_ifid_pc    <= r_hold_pc;
                            r_ifid_instr <= r_hold_instr;
                            r_state      <= c_st_fetch;
                        end
                    end
                    c_st_drop: begin
                        if (imem_ack) begin
                            r_state <= c_st_fetch;
                        end
                    end
                    default: r_state <= c_st_idle;
                endcase
            end
        end
    end

    assign ifid_valid = r_ifid_valid;
    assign ifid_pc    = r_ifid_pc;
    assign ifid_instr = r_ifid_instr;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_unit
// Purpose  : Directed and randomized checks of pc_fetch_unit against a
//            program-order instruction stream model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst0, stall0, redir0, req0, ack0, valid0;
    logic [31:0] rpc0, addr0, rdata0, pc0, instr0;
    logic        rst1, stall1, redir1, req1, ack1, valid1;
    logic [31:0] rpc1, addr1, rdata1, pc1, instr1;

    int n_total = 0;
    int n_bad   = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign rdata0 = mem_word(addr0);
    assign rdata1 = mem_word(addr1);

    pc_fetch_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000)) u_dut0 (
        .clk(clk), .rst(rst0), .stall(stall0), .redirect_valid(redir0),
        .redirect_pc(rpc0), .imem_req(req0), .imem_addr(addr0),
        .imem_ack(ack0), .imem_rdata(rdata0), .ifid_valid(valid0),
        .ifid_pc(pc0), .ifid_instr(instr0)
    );

    pc_fetch_unit #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) u_dut1 (
        .clk(clk), .rst(rst1), .stall(stall1), .redirect_valid(redir1),
        .redirect_pc(rpc1), .imem_req(req1), .imem_addr(addr1),
        .imem_ack(ack1), .imem_rdata(rdata1), .ifid_valid(valid1),
        .ifid_pc(pc1), .ifid_instr(instr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [31:0] exp_pc;
    logic [31:0] p_addr, p_pc;
    logic        p_req, p_ack, p_valid, p_stall, p_redir;
    int          cons, idle_cnt;

    initial begin
        rst0 = 1'b1; stall0 = 1'b0; redir0 = 1'b0; rpc0 = '0; ack0 = 1'b0;
        rst1 = 1'b1; stall1 = 1'b0; redir1 = 1'b0; rpc1 = '0; ack1 = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", {31'b0, req0}, 32'd0);
        chk("rst_addr", addr0, 32'h0);
        chk("rst_valid", {31'b0, valid0}, 32'd0);
        chk("rst_pc", pc0, 32'h0);
        chk("rst_instr", instr0, 32'h0);

        // Directed: start-up latency, then a 3-cycle ack delay on 0x4
        @(negedge clk); rst0 = 1'b0; ack0 = 1'b1; #1;
        chk("c0_req", {31'b0, req0}, 32'd0);
        @(negedge clk); #1;
        chk("c1_req", {31'b0, req0}, 32'd1);
        chk("c1_addr", addr0, 32'h0);
        @(negedge clk); ack0 = 1'b0; #1;
        chk("c2_valid", {31'b0, valid0}, 32'd1);
        chk("c2_pc", pc0, 32'h0);
        chk("c2_instr", instr0, mem_word(32'h0));
        chk("c2_addr", addr0, 32'h4);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            chk("dly_req", {31'b0, req0}, 32'd1);
            chk("dly_addr", addr0, 32'h4);
            chk("dly_valid", {31'b0, valid0}, 32'd0);
        end
        @(negedge clk); ack0 = 1'b1; #1;
        chk("dly_req", {31'b0, req0}, 32'd1);
        chk("dly_addr", addr0, 32'h4);
        chk("dly_valid", {31'b0, valid0}, 32'd0);
        @(negedge clk); #1;
        chk("dly_out_valid", {31'b0, valid0}, 32'd1);
        chk("dly_out_pc", pc0, 32'h4);
        chk("dly_out_instr", instr0, mem_word(32'h4));
        chk("dly_next_addr", addr0, 32'h8);

        // Randomized: consumed stream must follow program order
        @(negedge clk); rst0 = 1'b1; ack0 = 1'b0;
        @(negedge clk); rst0 = 1'b0;
        exp_pc = 32'h0; cons = 0; idle_cnt = 0;
        p_req = 1'b0; p_ack = 1'b0; p_valid = 1'b0; p_stall = 1'b0; p_redir = 1'b0;
        p_addr = '0; p_pc = '0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            stall0 = ($urandom_range(0, 99) < 30);
            ack0   = ($urandom_range(0, 99) < 55);
            redir0 = ($urandom_range(0, 99) < 4);
            rpc0   = $urandom & 32'h0000_0FFF;
            #1;
            if (p_req && !p_ack) begin
                chk("req_held", {31'b0, req0}, 32'd1);
                chk("addr_held", addr0, p_addr);
            end
            if (p_redir) chk("redir_flush", {31'b0, valid0}, 32'd0);
            if (p_valid && p_stall && !p_redir) begin
                chk("stall_valid", {31'b0, valid0}, 32'd1);
                chk("stall_pc", pc0, p_pc);
            end
            if (p_req && p_ack && p_valid && p_stall && !p_redir)
                chk("hold_req", {31'b0, req0}, 32'd0);
            if (req0) chk("addr_align", {30'b0, addr0[1:0]}, 32'd0);
            if (valid0 && !stall0) begin
                chk("stream_pc", pc0, exp_pc);
                chk("stream_instr", instr0, mem_word(pc0));
                exp_pc = exp_pc + 32'd4;
                cons++;
                idle_cnt = 0;
            end else begin
                idle_cnt++;
            end
            if (redir0) exp_pc = {rpc0[31:2], 2'b00};
            if (idle_cnt > 300) begin
                chk("watchdog", idle_cnt, 32'd0);
                break;
            end
            p_req = req0; p_ack = ack0; p_addr = addr0; p_valid = valid0;
            p_stall = stall0; p_redir = redir0; p_pc = pc0;
        end
        chk("progress", {31'b0, (cons > 200)}, 32'd1);
        @(negedge clk); redir0 = 1'b0; stall0 = 1'b0;

        // Directed: PC wrap on second instance, then mid-stream reset
        @(negedge clk); rst1 = 1'b0; ack1 = 1'b1; #1;
        chk("wrap_c0_req", {31'b0, req1}, 32'd0);
        @(negedge clk); #1;
        chk("wrap_c1_req", {31'b0, req1}, 32'd1);
        chk("wrap_c1_addr", addr1, 32'hFFFF_FFFC);
        @(negedge clk); #1;
        chk("wrap_c2_addr", addr1, 32'h0000_0000);
        chk("wrap_c2_pc", pc1, 32'hFFFF_FFFC);
        chk("wrap_c2_instr", instr1, mem_word(32'hFFFF_FFFC));
        @(negedge clk); #1;
        chk("wrap_c3_addr", addr1, 32'h0000_0004);
        chk("wrap_c3_pc", pc1, 32'h0000_0000);
        @(negedge clk); rst1 = 1'b1;
        @(negedge clk); #1;
        chk("midrst_req", {31'b0, req1}, 32'd0);
        chk("midrst_valid", {31'b0, valid1}, 32'd0);
        chk("midrst_addr", addr1, 32'hFFFF_FFFC);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
